// File: rtl/evb_ctrl_param_pkg.sv
// Shared types and helpers for the block-evaluation controller.
package evb_ctrl_param_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    localparam int unsigned STATUS_W  = 32;
    localparam logic [STATUS_W-1:0] STATUS_OK = 32'd0;

    // Ceiling log2, never less than 1 so single-entry ranges still get a bit.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((w < 31) && ((32'd1 << w) < value)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/evb_ctrl_param_if.sv
// Evaluator job handshake plus the result stream towards the consumer.
interface evb_ctrl_param_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    import evb_ctrl_param_pkg::*;

    logic                evp_start;
    logic [ADDR_W-1:0]   evp_addr;
    logic                evp_done;
    logic [DATA_W-1:0]   evp_result;
    logic [STATUS_W-1:0] evp_status;

    logic                res_valid;
    logic                res_ready;
    logic [DATA_W-1:0]   res_data;
    logic [STATUS_W-1:0] res_status;
    logic                res_last;

    // Controller side.
    modport master (
        output evp_start, evp_addr,
        input  evp_done, evp_result, evp_status,
        output res_valid, res_data, res_status, res_last,
        input  res_ready
    );

    // Evaluator / consumer side.
    modport slave (
        input  evp_start, evp_addr,
        output evp_done, evp_result, evp_status,
        input  res_valid, res_data, res_status, res_last,
        output res_ready
    );

endinterface

// File: rtl/evb_ctrl_param_result_fifo.sv
// First-word-fall-through result FIFO; head is always visible on pop_data.
module evb_result_fifo
    import evb_ctrl_param_pkg::*;
#(
    parameter  int unsigned WIDTH = 65,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = clog2_min1(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             push_ok, pop_ok;

    // Pointer/count update; a push into a full FIFO is accepted only alongside a pop.
    always_comb begin
        pop_ok   = pop && !empty_q;
        push_ok  = push && (!full_q || pop_ok);
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        empty_d  = (count_d == '0);
        full_d   = (count_d == CNT_W'(DEPTH));
    end

    // Storage and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = empty_q;
    assign full     = full_q;

endmodule

// File: rtl/evb_ctrl_param.sv
// Block-evaluation controller: one evaluator job per x-buffer point, results queued.
module evb_ctrl_param
    import evb_ctrl_param_pkg::*;
#(
    parameter  int unsigned BUFFER_SIZE   = 1024,
    parameter  int unsigned DATA_W        = 32,
    parameter  int unsigned CNT_W         = 5,
    parameter  int unsigned FIFO_DEPTH    = 4,
    parameter  bit          STOP_ON_ERROR = 1'b1,
    localparam int unsigned ADDR_W        = clog2_min1(BUFFER_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_evb,
    input  logic [CNT_W-1:0]  b,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              abort,
    evb_ctrl_param_if.master  bus,
    output logic              busy,
    output logic              done_evb,
    output logic              err,
    output logic [CNT_W-1:0]  points_done
);

    localparam int unsigned CNT1_W  = CNT_W + 1;
    localparam int unsigned ENTRY_W = DATA_W + STATUS_W + 1;
    localparam int unsigned FCNT_W  = clog2_min1(FIFO_DEPTH) + 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    b_lat_q, b_lat_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                abort_pend_q, abort_pend_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    points_done_q, points_done_d;
    logic                evp_start_q, evp_start_d;
    logic [ADDR_W-1:0]   evp_addr_q, evp_addr_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic                fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [ENTRY_W-1:0]  fifo_push_data, fifo_pop_data;
    logic [FCNT_W-1:0]   fifo_count;
    logic                last_c;
    logic                status_bad_c;

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        b_lat_d       = b_lat_q;
        base_d        = base_q;
        abort_pend_d  = abort_pend_q;
        err_d         = err_q;
        points_done_d = points_done_q;
        evp_start_d   = 1'b0;
        evp_addr_d    = evp_addr_q;
        done_d        = 1'b0;
        fifo_push     = 1'b0;

        status_bad_c  = (bus.evp_status != STATUS_OK);
        last_c        = ((CNT1_W'(idx_q) + CNT1_W'(1)) == CNT1_W'(b_lat_q))
                        || abort_pend_q || abort
                        || (STOP_ON_ERROR && status_bad_c);
        fifo_push_data = {bus.evp_result, bus.evp_status, last_c};

        if ((state_q != ST_IDLE) && abort) begin
            abort_pend_d = 1'b1;
            err_d        = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_evb) begin
                    b_lat_d       = b;
                    base_d        = base_addr;
                    err_d         = 1'b0;
                    points_done_d = '0;
                    idx_d         = '0;
                    state_d       = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((idx_q == b_lat_q) || abort_pend_q || (STOP_ON_ERROR && err_q)) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                end else if (fifo_count < FCNT_W'(FIFO_DEPTH)) begin
                    state_d     = ST_LAUNCH;
                    evp_start_d = 1'b1;
                    evp_addr_d  = base_q + ADDR_W'(idx_q);
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.evp_done) begin
                    fifo_push     = 1'b1;
                    idx_d         = idx_q + CNT_W'(1);
                    points_done_d = points_done_q + CNT_W'(1);
                    if (status_bad_c) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_CHECK;
                end
            end
            ST_FINISH: begin
                abort_pend_d = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Controller state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            b_lat_q       <= '0;
            base_q        <= '0;
            abort_pend_q  <= 1'b0;
            err_q         <= 1'b0;
            points_done_q <= '0;
            evp_start_q   <= 1'b0;
            evp_addr_q    <= '0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            b_lat_q       <= b_lat_d;
            base_q        <= base_d;
            abort_pend_q  <= abort_pend_d;
            err_q         <= err_d;
            points_done_q <= points_done_d;
            evp_start_q   <= evp_start_d;
            evp_addr_q    <= evp_addr_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    assign fifo_pop = bus.res_valid && bus.res_ready;

    evb_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_pop_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Launch is gated on free space and only one job is in flight, so a blind overflow is a bug.
    assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full && !fifo_pop));

    assign bus.evp_start = evp_start_q;
    assign bus.evp_addr  = evp_addr_q;
    assign bus.res_valid = !fifo_empty;
    assign {bus.res_data, bus.res_status, bus.res_last} = fifo_pop_data;

    assign busy        = busy_q;
    assign done_evb    = done_q;
    assign err         = err_q;
    assign points_done = points_done_q;

endmodule
